div: RTL and testbench
======================

Name: div

Overview:
- Sequential signed 32-bit integer divider implementing MIPS DIV. It is the inverse-direction companion of the Booth multiplier in the ALU datapath.
- Produces quotient on lo_div and remainder on hi_div, for writing into the LO/HI registers by the control unit.
- Algorithm: restoring shift-subtract on magnitudes, one quotient bit per clock, then a sign-fix cycle. The control FSM drives start and waits for done.

Parameters:
- WIDTH, 32, operand/result width; only 32 is verified.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clock.
- start  input  1  request; sampled only in IDLE.
- dividend  input  WIDTH  signed numerator (rs); captured on the accepted start edge.
- divisor  input  WIDTH  signed denominator (rt); captured on the accepted start edge.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse; results valid in that cycle and held afterwards.
- div_zero  output  1  one-cycle pulse coincident with done when divisor == 0.
- hi_div  output  WIDTH  signed remainder.
- lo_div  output  WIDTH  signed quotient.

Behaviour:
- Reset (reset==0 at a clock edge): FSM→IDLE; busy, done, div_zero, hi_div, lo_div, counter and internal registers all 0. Reset has priority over everything, including mid-operation: the operation is aborted with no done pulse.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - start==1 and divisor!=0: latch sign_q = dividend[31]^divisor[31], sign_r = dividend[31], |dividend|→Q, |divisor|→M (33-bit), R=0, count=0; go to RUN; busy=1.
  - start==1 and divisor==0: go to DONE with div_zero flagged. hi_div/lo_div keep their previous values.
- RUN, each cycle:
  - {R,Q} shifted left 1.
  - T = R_shifted − M (33-bit). If T ≥ 0: R=T, Q[0]=1; else R unchanged, Q[0]=0.
  - count+1. After the 32nd iteration (count reaches 31 then increments), go to FIX.
- FIX:
  - lo_div = sign_q ? −Q : Q.
  - hi_div = sign_r ? −R[31:0] : R[31:0].
  - Go to DONE.
- DONE: done=1 for exactly this cycle (div_zero=1 too if flagged), busy=0, then IDLE.
- Latency: start accepted at edge E → done high in the cycle following edge E+34. Divide-by-zero: done after edge E+1.
- Width/sign rules:
  - Quotient truncates toward zero; remainder takes the sign of the dividend; |remainder| < |divisor|.
  - Magnitudes are 32-bit unsigned, so |−2^31| = 0x80000000 is exact.
  - −2^31 / −1 → lo_div=0x80000000 (wraps), hi_div=0; no exception, div_zero=0.
- start while busy (RUN/FIX/DONE) is ignored; operands are not re-captured. start held high through DONE→IDLE launches a new operation on the first IDLE edge.
- Outputs hi_div/lo_div change only in FIX or on reset. Operand inputs may change freely after capture.

Test Plan:
- 7 / 2 → after 34 cycles, done pulse; lo_div=3, hi_div=1; busy high for exactly 34 cycles.
- −7 / 2 → lo_div=0xFFFFFFFD (−3), hi_div=0xFFFFFFFF (−1). 7 / −2 → lo_div=0xFFFFFFFD, hi_div=1. −7 / −2 → lo_div=3, hi_div=0xFFFFFFFF.
- After a prior result (lo=3, hi=1), 100 / 0 → done and div_zero both pulse one cycle after acceptance; lo_div=3, hi_div=1 unchanged.
- 0x80000000 / 0xFFFFFFFF → lo_div=0x80000000, hi_div=0, div_zero=0. 0x7FFFFFFF / 1 → lo=0x7FFFFFFF, hi=0. 5 / 9 → lo=0, hi=5.
- Start 1000/7; toggle start and change operands every cycle mid-RUN → result stays lo=142, hi=6. Assert start on the DONE cycle → new operation begins on the next edge.
- Drive reset=0 for one edge at iteration 10 of a division → next cycle: busy=0, done=0, hi_div=lo_div=0, FSM in IDLE; no done pulse follows. A fresh 9/3 then yields lo=3, hi=0.

Source files
------------

// File: rtl/div_if.sv
// Handshake and result bundle between the control unit and the sequential divider.
// The control unit owns start/operands; the divider owns status and the HI/LO results.
interface div_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi_div;
    logic [WIDTH-1:0] lo_div;

    modport master (
        output start, dividend, divisor,
        input  busy, done, div_zero, hi_div, lo_div
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, div_zero, hi_div, lo_div
    );
endinterface

// File: rtl/div.sv
// Signed restoring divider (MIPS DIV): quotient on lo_div, remainder on hi_div.
// Latency: done pulses in the cycle after edge E+34 (E = accepting edge); divide-by-zero after E+1.
// Backpressure: none; start is only sampled in IDLE, ignored while an operation is in flight.
module div #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic  clock,
    input  logic  reset,
    div_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH:0]     mag_m;
    logic [CNT_W-1:0]   count;
    logic               sign_q;
    logic               sign_r;
    logic               dz_flag;
    logic               busy_r;
    logic               done_r;
    logic               div_zero_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;

    logic [WIDTH-1:0]   dvd_mag;
    logic [WIDTH-1:0]   dvs_mag;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     trial;

    // Magnitudes are unsigned, so |-2^31| = 0x80000000 is represented exactly.
    always_comb begin
        dvd_mag = bus.dividend[WIDTH-1] ? (~bus.dividend + 1'b1) : bus.dividend;
        dvs_mag = bus.divisor[WIDTH-1]  ? (~bus.divisor  + 1'b1) : bus.divisor;
        rem_sh  = {rem_q, quo_q[WIDTH-1]};
        trial   = rem_sh - mag_m;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            rem_q      <= '0;
            quo_q      <= '0;
            mag_m      <= '0;
            count      <= '0;
            sign_q     <= 1'b0;
            sign_r     <= 1'b0;
            dz_flag    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
            hi_r       <= '0;
            lo_r       <= '0;
        end else begin
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        busy_r <= 1'b1;
                        if (bus.divisor == '0) begin
                            dz_flag <= 1'b1;
                            state   <= DONE;
                        end else begin
                            dz_flag <= 1'b0;
                            sign_q  <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                            sign_r  <= bus.dividend[WIDTH-1];
                            quo_q   <= dvd_mag;
                            mag_m   <= {1'b0, dvs_mag};
                            rem_q   <= '0;
                            count   <= '0;
                            state   <= RUN;
                        end
                    end
                end
                RUN: begin
                    // Both operands of the trial subtract are below 2^WIDTH, so bit WIDTH is the sign.
                    if (!trial[WIDTH]) begin
                        rem_q <= trial[WIDTH-1:0];
                        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_q <= rem_sh[WIDTH-1:0];
                        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
                    end
                    count <= count + 1'b1;
                    if (count == CNT_W'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    lo_r  <= sign_q ? (~quo_q + 1'b1) : quo_q;
                    hi_r  <= sign_r ? (~rem_q + 1'b1) : rem_q;
                    state <= DONE;
                end
                DONE: begin
                    done_r     <= 1'b1;
                    div_zero_r <= dz_flag;
                    busy_r     <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.div_zero = div_zero_r;
    assign bus.hi_div   = hi_r;
    assign bus.lo_div   = lo_r;
endmodule

// File: tb/tb_div.sv
// Scoreboard bench for the sequential signed divider: stimulus pushes expected HI/LO/div_zero,
// a negedge monitor pops and compares on every done pulse.
module tb_div;
    logic clock = 1'b0;
    logic reset = 1'b0;

    div_if #(.WIDTH(32)) bus ();

    div #(.WIDTH(32), .CNT_W(6)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dz;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (reset && bus.done) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got lo=%h hi=%h want no done", bus.lo_div, bus.hi_div);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("lo_div", bus.lo_div, e.lo);
                chk("hi_div", bus.hi_div, e.hi);
                chk("div_zero", {31'b0, bus.div_zero}, {31'b0, e.dz});
            end
        end
        if (reset && bus.div_zero && !bus.done) begin
            total++;
            bad++;
            $display("FAIL dz_without_done: got div_zero=1 done=0 want coincident");
        end
    end

    // Called at a negedge; start is accepted at the next posedge (edge E).
    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] elo, input logic [31:0] ehi,
                           input logic edz, input logic scramble);
        int n;
        int busy_cnt;
        bit seen;
        exp_t e;
        e.lo = elo;
        e.hi = ehi;
        e.dz = edz;
        exp_q.push_back(e);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        chk("busy_after_accept", {31'b0, bus.busy}, 32'd1);
        n = 0;
        busy_cnt = 0;
        seen = 1'b0;
        while (n < 100 && !seen) begin
            @(negedge clock);
            n++;
            if (scramble && n < 20) begin
                bus.start    = ~bus.start;
                bus.dividend = $urandom;
                bus.divisor  = (n % 4 == 0) ? 32'd0 : $urandom;
            end else if (scramble) begin
                bus.start = 1'b0;
            end
            if (bus.done) seen = 1'b1;
            else if (bus.busy) busy_cnt++;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL timeout: got no done after %0d cycles want done", n);
        end else begin
            chk("latency", n, edz ? 32'd2 : 32'd35);
            chk("busy_cycles", busy_cnt, edz ? 32'd1 : 32'd34);
            chk("busy_at_done", {31'b0, bus.busy}, 32'd0);
        end
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        reset        = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_done", {31'b0, bus.done}, 32'd0);
        chk("rst_dz", {31'b0, bus.div_zero}, 32'd0);
        chk("rst_hi", bus.hi_div, 32'd0);
        chk("rst_lo", bus.lo_div, 32'd0);
        reset = 1'b1;
        @(negedge clock);

        // Each call starts on the done cycle of the previous one, so back-to-back launch is exercised.
        run_div(32'd7, 32'd2, 32'd3, 32'd1, 1'b0, 1'b0);
        run_div(32'd100, 32'd0, 32'd3, 32'd1, 1'b1, 1'b0);
        run_div(-32'sd7, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0);
        run_div(32'd7, -32'sd2, 32'hFFFFFFFD, 32'd1, 1'b0, 1'b0);
        run_div(-32'sd7, -32'sd2, 32'd3, 32'hFFFFFFFF, 1'b0, 1'b0);
        run_div(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 1'b0);
        run_div(32'h7FFFFFFF, 32'd1, 32'h7FFFFFFF, 32'd0, 1'b0, 1'b0);
        run_div(32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 1'b0);
        run_div(32'h80000000, 32'd7, 32'hEDB6DB6E, 32'hFFFFFFFE, 1'b0, 1'b0);
        run_div(32'd1000, 32'd7, 32'd142, 32'd6, 1'b0, 1'b1);

        // Abort mid-run with reset: no done may follow.
        repeat (2) @(negedge clock);
        bus.start    = 1'b1;
        bus.dividend = 32'd123456;
        bus.divisor  = 32'd7;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        repeat (10) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("abort_busy", {31'b0, bus.busy}, 32'd0);
        chk("abort_done", {31'b0, bus.done}, 32'd0);
        chk("abort_hi", bus.hi_div, 32'd0);
        chk("abort_lo", bus.lo_div, 32'd0);
        reset = 1'b1;
        repeat (50) @(negedge clock);
        chk("abort_idle_busy", {31'b0, bus.busy}, 32'd0);

        run_div(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0);
        repeat (5) @(negedge clock);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
